// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: streams a program image into the I-cache while
// holding the core in reset, then drives per-cycle PC/fetch/flush controls.
module fetch_controller #(
  parameter int PROG_WORDS   = 256,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_valid_i,
  input  logic [31:0] load_data_i,
  input  logic        load_last_i,
  output logic        load_ready_o,
  output logic        wr_instr_en_o,
  output logic [31:0] wr_instr_o,
  output logic [63:0] wr_addr_o,
  output logic        cpu_rst_o,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  output logic        pc_en_o,
  output logic        if_en_o,
  output logic        pc_src_o,
  output logic        flush_o,
  output logic [15:0] load_count_o,
  output logic        load_err_o
);

  typedef enum logic [1:0] {LOAD, DRAIN, RUN, REDIRECT} state_t;

  localparam int          FW        = $clog2(FLUSH_CYCLES + 1);
  localparam logic [15:0] LAST_IDX  = 16'(PROG_WORDS - 1);
  localparam logic [FW-1:0] FLUSH_LD = FW'(FLUSH_CYCLES);
  localparam logic [FW-1:0] ONE      = FW'(1);

  state_t        state;
  state_t        cur;
  logic [FW-1:0] fcnt;
  logic          hs;

  // Reset forces the control outputs to their LOAD values immediately.
  always_comb begin
    cur = rst_i ? LOAD : state;
  end

  always_comb begin
    load_ready_o = 1'b0;
    cpu_rst_o    = 1'b0;
    pc_en_o      = 1'b0;
    if_en_o      = 1'b0;
    pc_src_o     = 1'b0;
    flush_o      = 1'b0;
    case (cur)
      LOAD: begin
        load_ready_o = 1'b1;
        cpu_rst_o    = 1'b1;
      end
      DRAIN: cpu_rst_o = 1'b1;
      RUN: begin
        if (branch_taken_i) begin
          pc_en_o  = 1'b1;
          pc_src_o = 1'b1;
        end else if (!stall_i) begin
          pc_en_o = 1'b1;
          if_en_o = 1'b1;
        end
      end
      REDIRECT: begin
        flush_o = 1'b1;
        if (branch_taken_i) begin
          pc_en_o  = 1'b1;
          pc_src_o = 1'b1;
        end else begin
          pc_en_o = ~stall_i;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    hs = load_valid_i & load_ready_o;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= LOAD;
      load_count_o  <= '0;
      load_err_o    <= 1'b0;
      wr_instr_en_o <= 1'b0;
      wr_instr_o    <= '0;
      wr_addr_o     <= '0;
      fcnt          <= '0;
    end else begin
      wr_instr_en_o <= hs;
      case (state)
        LOAD: begin
          if (hs) begin
            wr_instr_o   <= load_data_i;
            wr_addr_o    <= {46'b0, load_count_o, 2'b00};
            load_count_o <= load_count_o + 16'd1;
            if (load_last_i) begin
              state <= DRAIN;
            end else if (load_count_o == LAST_IDX) begin
              // Overrun: the word filling the last slot closes the image.
              load_err_o <= 1'b1;
              state      <= DRAIN;
            end
          end
        end
        DRAIN: state <= RUN;
        RUN: begin
          if (branch_taken_i) begin
            fcnt  <= FLUSH_LD;
            state <= REDIRECT;
          end
        end
        REDIRECT: begin
          if (branch_taken_i) begin
            fcnt <= FLUSH_LD;
          end else begin
            fcnt <= fcnt - ONE;
            if (fcnt == ONE) state <= RUN;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed self-checking bench for fetch_controller (default and PROG_WORDS=4).
module tb_fetch_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        rst, valid, last, stall, branch;
  logic [31:0] data;
  logic        ready, wr_en, cpu_rst, pc_en, if_en, pc_src, flush, err;
  logic [31:0] wr_instr;
  logic [63:0] wr_addr;
  logic [15:0] count;

  logic        rst4, valid4;
  logic [31:0] data4;
  logic        ready4, wr_en4, cpu_rst4, pc_en4, if_en4, pc_src4, flush4, err4;
  logic [31:0] wr_instr4;
  logic [63:0] wr_addr4;
  logic [15:0] count4;

  fetch_controller dut (
    .clk_i(clk), .rst_i(rst), .load_valid_i(valid), .load_data_i(data),
    .load_last_i(last), .load_ready_o(ready), .wr_instr_en_o(wr_en),
    .wr_instr_o(wr_instr), .wr_addr_o(wr_addr), .cpu_rst_o(cpu_rst),
    .stall_i(stall), .branch_taken_i(branch), .pc_en_o(pc_en), .if_en_o(if_en),
    .pc_src_o(pc_src), .flush_o(flush), .load_count_o(count), .load_err_o(err)
  );

  fetch_controller #(.PROG_WORDS(4), .FLUSH_CYCLES(2)) dut4 (
    .clk_i(clk), .rst_i(rst4), .load_valid_i(valid4), .load_data_i(data4),
    .load_last_i(1'b0), .load_ready_o(ready4), .wr_instr_en_o(wr_en4),
    .wr_instr_o(wr_instr4), .wr_addr_o(wr_addr4), .cpu_rst_o(cpu_rst4),
    .stall_i(1'b0), .branch_taken_i(1'b0), .pc_en_o(pc_en4), .if_en_o(if_en4),
    .pc_src_o(pc_src4), .flush_o(flush4), .load_count_o(count4), .load_err_o(err4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [31:0] img [4];

  initial begin
    img[0] = 32'h00000013; img[1] = 32'h00100093;
    img[2] = 32'h00208113; img[3] = 32'h00000073;
    rst = 1'b1; valid = 1'b0; last = 1'b0; data = '0; stall = 1'b0; branch = 1'b0;
    rst4 = 1'b1; valid4 = 1'b0; data4 = '0;

    // Reset state (rst still high)
    tick(); tick();
    chk("rst_count", count, 0);
    chk("rst_err", err, 0);
    chk("rst_wren", wr_en, 0);
    chk("rst_addr", wr_addr, 0);
    chk("rst_ready", ready, 1);
    chk("rst_cpurst", cpu_rst, 1);
    chk("rst_pcen", pc_en, 0);
    rst = 1'b0;
    tick();

    // Back-to-back 4-word image
    for (int i = 0; i < 4; i++) begin
      valid = 1'b1; data = img[i]; last = (i == 3);
      #1 chk("ld_ready", ready, 1);
      tick();
      chk("ld_wren", wr_en, 1);
      chk("ld_data", wr_instr, img[i]);
      chk("ld_addr", wr_addr, 64'(4 * i));
      chk("ld_count", count, 16'(i + 1));
    end
    valid = 1'b0; last = 1'b0;
    #1;
    chk("drain_ready", ready, 0);
    chk("drain_cpurst", cpu_rst, 1);
    tick();
    chk("run_wren", wr_en, 0);
    chk("run_cpurst", cpu_rst, 0);
    chk("run_count", count, 4);
    chk("run_err", err, 0);
    chk("run_pcen", pc_en, 1);
    chk("run_ifen", if_en, 1);
    chk("run_src", pc_src, 0);
    chk("run_flush", flush, 0);

    // Loader ignored in RUN
    valid = 1'b1; data = 32'hdeadbeef;
    #1 chk("run_noready", ready, 0);
    tick();
    chk("run_nowrite", wr_en, 0);
    valid = 1'b0;

    // Stall for 3 cycles
    for (int i = 0; i < 3; i++) begin
      stall = 1'b1;
      #1 chk("stall_pcen", pc_en, 0);
      chk("stall_ifen", if_en, 0);
      tick();
    end
    stall = 1'b0;
    #1 chk("unstall_pcen", pc_en, 1);
    chk("unstall_ifen", if_en, 1);

    // Branch overrides stall; stall during redirect gates pc_en
    stall = 1'b1; branch = 1'b1;
    #1 chk("bs_pcen", pc_en, 1);
    chk("bs_src", pc_src, 1);
    chk("bs_ifen", if_en, 0);
    tick();
    stall = 1'b0; branch = 1'b0;
    #1 chk("rd1_flush", flush, 1);
    chk("rd1_ifen", if_en, 0);
    chk("rd1_pcen", pc_en, 1);
    chk("rd1_src", pc_src, 0);
    tick();
    stall = 1'b1;
    #1 chk("rd2_flush", flush, 1);
    chk("rd2_pcen", pc_en, 0);
    tick();
    stall = 1'b0;
    #1 chk("rd_end_flush", flush, 0);
    chk("rd_end_ifen", if_en, 1);

    // Single branch pulse
    branch = 1'b1;
    #1 chk("bp_src", pc_src, 1);
    chk("bp_flush", flush, 0);
    tick();
    branch = 1'b0;
    #1 chk("bp_f1", flush, 1);
    chk("bp_f1_src", pc_src, 0);
    tick();
    chk("bp_f2", flush, 1);
    tick();
    chk("bp_f3", flush, 0);
    chk("bp_ifen", if_en, 1);

    // Second branch during first flush cycle
    branch = 1'b1;
    tick();
    #1 chk("b2_flush", flush, 1);
    chk("b2_src", pc_src, 1);
    chk("b2_pcen", pc_en, 1);
    tick();
    branch = 1'b0;
    #1 chk("b2_f1", flush, 1);
    tick();
    chk("b2_f2", flush, 1);
    tick();
    chk("b2_f3", flush, 0);

    // Reset mid-redirect: outputs behave as LOAD while rst is high
    branch = 1'b1;
    tick();
    branch = 1'b0; rst = 1'b1;
    #1 chk("rr_flush", flush, 0);
    chk("rr_ready", ready, 1);
    chk("rr_cpurst", cpu_rst, 1);
    tick();
    rst = 1'b0;
    #1 chk("rr_count", count, 0);

    // Reset after 2 of 5 words
    for (int i = 0; i < 2; i++) begin
      valid = 1'b1; data = 32'h1000 + 32'(i); last = 1'b0;
      tick();
    end
    chk("ml_count2", count, 2);
    valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    #1 chk("ml_count0", count, 0);
    chk("ml_wren", wr_en, 0);
    chk("ml_addr", wr_addr, 0);
    chk("ml_ready", ready, 1);
    chk("ml_cpurst", cpu_rst, 1);

    // Gapped load restarting at address 0
    for (int i = 0; i < 3; i++) begin
      valid = 1'b1; data = 32'hA000 + 32'(i); last = (i == 2);
      tick();
      chk("gap_wren", wr_en, 1);
      chk("gap_addr", wr_addr, 64'(4 * i));
      chk("gap_data", wr_instr, 32'hA000 + 32'(i));
      valid = 1'b0; last = 1'b0;
      tick();
      chk("gap_nowr", wr_en, 0);
    end
    chk("gap_count", count, 3);
    chk("gap_cpurst", cpu_rst, 0);

    // Overrun with PROG_WORDS=4
    rst4 = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) begin
      valid4 = 1'b1; data4 = 32'hB000 + 32'(i);
      #1 chk("ov_ready", ready4, (i < 4) ? 1'b1 : 1'b0);
      tick();
      chk("ov_wren", wr_en4, (i < 4) ? 1'b1 : 1'b0);
      if (i < 4) chk("ov_addr", wr_addr4, 64'(4 * i));
    end
    valid4 = 1'b0;
    #1 chk("ov_count", count4, 4);
    chk("ov_err", err4, 1);
    chk("ov_lastaddr", wr_addr4, 12);
    chk("ov_cpurst", cpu_rst4, 0);
    chk("ov_ready_after", ready4, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
Sequences the instruction-fetch stage. After reset it holds the core in reset while a program image streams into the instruction cache over a valid/ready port. It then releases the core and generates per-cycle PC-enable, fetch-enable, PC-source and flush controls from the hazard-unit stall and the execute-stage branch-taken signal. It sits between the boot/debug loader, the hazard unit, the branch unit and the fetch stage.

Parameters:
PROG_WORDS, 256, maximum number of 32-bit instruction words accepted in one load (must be at least 2)
FLUSH_CYCLES, 2, number of cycles flush_o stays asserted after a taken branch (must be at least 1)

Ports:
clk_i  input  1  clock; all state changes on the rising edge
rst_i  input  1  synchronous, active-high reset
load_valid_i  input  1  loader presents a word on load_data_i
load_data_i  input  32  instruction word to store
load_last_i  input  1  qualifies the current word as the final word of the image
load_ready_o  output  1  controller accepts a word this cycle
wr_instr_en_o  output  1  instruction-cache write strobe
wr_instr_o  output  32  instruction-cache write data
wr_addr_o  output  64  instruction-cache write byte address
cpu_rst_o  output  1  held-reset for the fetch stage and the rest of the core
stall_i  input  1  hazard-unit stall request
branch_taken_i  input  1  execute stage redirects the PC (target supplied to fetch directly)
pc_en_o  output  1  PC update enable
if_en_o  output  1  fetch-stage instruction register enable
pc_src_o  output  1  0 = sequential PC+4; 1 = branch target
flush_o  output  1  inject NOP into fetch output
load_count_o  output  16  number of words written by the last or current load
load_err_o  output  1  sticky: image overran PROG_WORDS

Behaviour:
- FSM states: LOAD, DRAIN, RUN, REDIRECT.
- Reset (rst_i=1 at an edge):
  - state goes to LOAD; load_count_o=0; load_err_o=0; wr_instr_en_o=0; wr_instr_o=0; wr_addr_o=0; flush counter=0.
  - This applies from any state, including mid-load and mid-redirect.
  - While rst_i is high, all combinational outputs behave as in LOAD.
- LOAD:
  - load_ready_o=1, cpu_rst_o=1; pc_en_o=if_en_o=pc_src_o=flush_o=0.
  - A handshake (valid&ready) registers the word. Next cycle: wr_instr_en_o=1, wr_instr_o=word, wr_addr_o=4*load_count_o (value before increment). load_count_o increments on the same edge. Write latency is exactly 1 cycle.
  - The write strobe is a single-cycle pulse per handshake; back-to-back handshakes give a continuous strobe with addresses 0, 4, 8, ...
  - A handshake with load_last_i=1 goes to DRAIN.
  - A handshake on word index PROG_WORDS-1 with load_last_i=0 sets load_err_o=1, treats the word as last and goes to DRAIN.
  - The load_count_o upper bits above the needed width read 0.
- DRAIN: exactly 1 cycle.
  - load_ready_o=0, cpu_rst_o=1; the final cache write occurs here.
  - Then go to RUN. cpu_rst_o is first low in the cycle after the final write.
- RUN:
  - load_ready_o=0 permanently (load_valid_i ignored until the next reset); cpu_rst_o=0; flush_o=0.
  - branch_taken_i=1: pc_en_o=1, pc_src_o=1, if_en_o=0, flush counter loads FLUSH_CYCLES, go to REDIRECT. Branch overrides stall.
  - Else stall_i=1: pc_en_o=0, if_en_o=0, pc_src_o=0.
  - Else: pc_en_o=1, if_en_o=1, pc_src_o=0.
- REDIRECT:
  - flush_o=1, if_en_o=0.
  - pc_en_o=~stall_i, pc_src_o=0; the counter decrements each cycle.
  - Go to RUN on the cycle the counter equals 1, so flush_o is high for exactly FLUSH_CYCLES cycles.
  - branch_taken_i=1 in REDIRECT: pc_en_o=1, pc_src_o=1, counter reloads FLUSH_CYCLES, stay in REDIRECT.
- All control outputs (pc_en_o, if_en_o, pc_src_o, flush_o, load_ready_o, cpu_rst_o) are combinational from state and inputs. Write-port outputs and counters are registered.

Test Plan:
- Reset, then 4 handshakes (0x00000013, 0x00100093, 0x00208113, 0x00000073 with last) -> strobes at addr 0, 4, 8, 12 one cycle after each handshake; load_count_o=4; cpu_rst_o falls 2 cycles after the final handshake; load_err_o=0.
- PROG_WORDS=4, 6 words offered without last -> only 4 accepted, load_err_o=1, load_ready_o=0 afterwards, writes only at addr 0 to 12.
- RUN with stall_i high 3 cycles -> pc_en_o=if_en_o=0 for exactly those 3 cycles; stall_i and branch_taken_i high together -> pc_en_o=1, pc_src_o=1.
- branch_taken_i single pulse, FLUSH_CYCLES=2 -> pc_src_o=1 for 1 cycle, flush_o=1 for the next 2 cycles, then if_en_o=1; a second branch in the 1st flush cycle extends flush_o to 2 cycles after that branch.
- rst_i asserted after 2 of 5 words loaded -> next cycle load_count_o=0, load_ready_o=1, cpu_rst_o=1; reload writes start again at addr 0.
- Load with load_valid_i toggling on alternate cycles -> no strobe in gap cycles, addresses contiguous.
